// File: rtl/hex_event_pkg.sv
// Shared types for the hex event arbiter: event payload, FSM state, default lane count.
package hex_event_pkg;

    localparam int HEX_NUM_SRC = 4;

    typedef struct packed {
        logic signed [15:0] q;
        logic signed [15:0] r;
        logic [7:0]         depth;
        logic [7:0]         material;
    } hex_event_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_START  = 2'd1,
        ARB_ACTIVE = 2'd2,
        ARB_DRAIN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/hex_event_arbiter_if.sv
// Lane-side handshake and event-writer bus of the hex event arbiter.
interface hex_event_arbiter_if
    import hex_event_pkg::*;
#(
    parameter int NUM_SRC = HEX_NUM_SRC
) ();

    logic [NUM_SRC-1:0]             src_valid;
    hex_event_t [NUM_SRC-1:0]       src_event;
    logic [NUM_SRC-1:0]             src_ready;
    logic                           wr_frame_start;
    logic                           wr_valid;
    hex_event_t                     wr_event;

    // master: rasterizer lanes + event writer; slave: the arbiter
    modport master (
        output src_valid, src_event,
        input  src_ready, wr_frame_start, wr_valid, wr_event
    );

    modport slave (
        input  src_valid, src_event,
        output src_ready, wr_frame_start, wr_valid, wr_event
    );

endinterface

// File: rtl/hex_event_arbiter_rr.sv
// Round-robin one-hot grant; pointer holds the last granted lane and moves only on a transfer.
module hex_rr_arbiter #(
    parameter  int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    logic [PW-1:0] ptr;

    always_comb begin
        logic          found;
        logic [PW-1:0] idx;
        found = 1'b0;
        idx   = '0;
        grant = '0;
        // search begins just after the last granted lane
        for (int k = 1; k <= N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PW'(N - 1);
        end else if (advance) begin
            for (int i = 0; i < N; i++)
                if (grant[i]) ptr <= PW'(i);
        end
    end

endmodule

// File: rtl/hex_event_arbiter.sv
// Per-frame arbiter: merges rasterizer lanes into one event writer, counts issued and dropped events.
module hex_event_arbiter
    import hex_event_pkg::*;
#(
    parameter  int NUM_SRC = HEX_NUM_SRC,
    parameter  int DEPTH   = 256,
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_req,
    input  logic                 frame_end,
    hex_event_arbiter_if.slave   bus,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic [CW-1:0]        issued_count,
    output logic [31:0]          drop_count,
    output logic                 drop_pulse
);

    arb_state_t         state;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic               xfer;
    logic               room;
    hex_event_t         sel_event;

    assign req = (state == ARB_ACTIVE) ? bus.src_valid : '0;

    hex_rr_arbiter #(.N(NUM_SRC)) u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .advance (xfer),
        .grant   (grant)
    );

    // grant only ever covers valid lanes, so any grant bit is a transfer
    assign bus.src_ready      = grant;
    assign xfer               = |grant;
    assign room               = issued_count < CW'(DEPTH);
    assign bus.wr_frame_start = (state == ARB_START);
    assign frame_busy         = (state != ARB_IDLE);

    always_comb begin
        sel_event = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (grant[i]) sel_event = bus.src_event[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ARB_IDLE;
            bus.wr_valid <= 1'b0;
            bus.wr_event <= '0;
            issued_count <= '0;
            drop_count   <= '0;
            drop_pulse   <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            bus.wr_valid <= xfer && room;
            drop_pulse   <= xfer && !room;
            frame_done   <= (state == ARB_DRAIN);
            if (xfer && room) begin
                bus.wr_event <= sel_event;
                issued_count <= issued_count + 1'b1;
            end
            // a full buffer never stalls the lanes; overflow is only counted
            if (xfer && !room && drop_count != '1)
                drop_count <= drop_count + 32'd1;
            case (state)
                ARB_IDLE: if (frame_req) begin
                    state        <= ARB_START;
                    issued_count <= '0;
                    drop_count   <= '0;
                end
                ARB_START:  state <= ARB_ACTIVE;
                ARB_ACTIVE: if (frame_end) state <= ARB_DRAIN;
                default:    state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_event_arbiter.sv
// Bench: two arbiters (DEPTH 256 and 4) on shared directed stimulus, checked against a cycle model.
module tb_hex_event_arbiter;
    import hex_event_pkg::*;

    localparam int NS = 4;

    logic clk = 1'b0;
    logic reset, frame_req, frame_end;
    logic [NS-1:0]       src_valid;
    hex_event_t [NS-1:0] src_event;

    always #5 clk = ~clk;

    hex_event_arbiter_if #(.NUM_SRC(NS)) bus0 ();
    hex_event_arbiter_if #(.NUM_SRC(NS)) bus1 ();
    assign bus0.src_valid = src_valid;
    assign bus0.src_event = src_event;
    assign bus1.src_valid = src_valid;
    assign bus1.src_event = src_event;

    logic        busy0, busy1, done0, done1, dp0, dp1;
    logic [8:0]  iss0;
    logic [2:0]  iss1;
    logic [31:0] drp0, drp1;

    hex_event_arbiter #(.NUM_SRC(NS), .DEPTH(256)) dut (
        .clk(clk), .reset(reset), .frame_req(frame_req), .frame_end(frame_end),
        .bus(bus0.slave), .frame_busy(busy0), .frame_done(done0),
        .issued_count(iss0), .drop_count(drp0), .drop_pulse(dp0)
    );

    hex_event_arbiter #(.NUM_SRC(NS), .DEPTH(4)) dut4 (
        .clk(clk), .reset(reset), .frame_req(frame_req), .frame_end(frame_end),
        .bus(bus1.slave), .frame_busy(busy1), .frame_done(done1),
        .issued_count(iss1), .drop_count(drp1), .drop_pulse(dp1)
    );

    int n_chk = 0;
    int n_pass = 0;
    bit armed = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase[2];  // 0 idle, 1 frame start, 2 accepting, 3 draining
    int          m_last[2];
    int          m_iss[2];
    logic [31:0] m_drp[2];
    logic        m_wv[2], m_done[2], m_dp[2];
    logic [47:0] m_we[2];
    int          m_depth[2] = '{256, 4};

    function automatic int rr_pick(input logic [3:0] v, input int last);
        logic [1:0] l;
        for (int k = 1; k <= 4; k++) begin
            l = 2'((last + k) % 4);
            if (v[l]) return int'(l);
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int lane;
        for (int m = 0; m < 2; m++) begin
            if (reset) begin
                m_phase[m] <= 0; m_last[m] <= 3; m_iss[m] <= 0; m_drp[m] <= '0;
                m_wv[m] <= 1'b0; m_done[m] <= 1'b0; m_dp[m] <= 1'b0; m_we[m] <= '0;
            end else begin
                lane = (m_phase[m] == 2) ? rr_pick(src_valid, m_last[m]) : -1;
                m_wv[m]   <= 1'b0;
                m_dp[m]   <= 1'b0;
                m_done[m] <= (m_phase[m] == 3);
                if (lane >= 0) begin
                    m_last[m] <= lane;
                    if (m_iss[m] < m_depth[m]) begin
                        m_wv[m]  <= 1'b1;
                        m_we[m]  <= src_event[2'(lane)];
                        m_iss[m] <= m_iss[m] + 1;
                    end else begin
                        m_dp[m] <= 1'b1;
                        if (m_drp[m] != 32'hFFFF_FFFF) m_drp[m] <= m_drp[m] + 32'd1;
                    end
                end
                case (m_phase[m])
                    0: if (frame_req) begin m_phase[m] <= 1; m_iss[m] <= 0; m_drp[m] <= '0; end
                    1: m_phase[m] <= 2;
                    2: if (frame_end) m_phase[m] <= 3;
                    default: m_phase[m] <= 0;
                endcase
            end
        end
    end

    task automatic cmp(input int m, input logic [3:0] rdy, input logic fs, input logic wv,
                       input logic [47:0] we, input logic busy, input logic done,
                       input logic [31:0] iss, input logic [31:0] drp, input logic dp);
        int p;
        logic [3:0] er;
        string t;
        t  = (m == 0) ? "d256" : "d4";
        p  = (m_phase[m] == 2) ? rr_pick(src_valid, m_last[m]) : -1;
        er = (p >= 0) ? 4'(1 << p) : 4'h0;
        chk({t, ".src_ready"},     64'(rdy),  64'(er));
        chk({t, ".wr_frame_start"},64'(fs),   64'(m_phase[m] == 1));
        chk({t, ".frame_busy"},    64'(busy), 64'(m_phase[m] != 0));
        chk({t, ".wr_valid"},      64'(wv),   64'(m_wv[m]));
        chk({t, ".wr_event"},      64'(we),   64'(m_we[m]));
        chk({t, ".frame_done"},    64'(done), 64'(m_done[m]));
        chk({t, ".issued_count"},  64'(iss),  64'(m_iss[m]));
        chk({t, ".drop_count"},    64'(drp),  64'(m_drp[m]));
        chk({t, ".drop_pulse"},    64'(dp),   64'(m_dp[m]));
    endtask

    int gq[$];
    int n_wv1, n_dp1, n_rdy2;

    always @(negedge clk) begin
        logic [3:0] g;
        if (armed) begin
            cmp(0, bus0.src_ready, bus0.wr_frame_start, bus0.wr_valid, bus0.wr_event,
                busy0, done0, 32'(iss0), drp0, dp0);
            cmp(1, bus1.src_ready, bus1.wr_frame_start, bus1.wr_valid, bus1.wr_event,
                busy1, done1, 32'(iss1), drp1, dp1);
            g = bus0.src_ready & src_valid;
            for (int i = 0; i < 4; i++) if (g[i]) gq.push_back(i);
            if (bus1.wr_valid) n_wv1++;
            if (dp1) n_dp1++;
            if (bus1.src_ready[2]) n_rdy2++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        frame_req = 1'b1; tick();
        frame_req = 1'b0; tick();
    endtask

    task automatic end_frame();
        frame_end = 1'b1; tick();
        frame_end = 1'b0; tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b1; frame_req = 1'b0; frame_end = 1'b0; src_valid = '0;
        for (int i = 0; i < NS; i++) begin
            src_event[i].q        = 16'(100 * i + 7);
            src_event[i].r        = -16'(i + 1);
            src_event[i].depth    = 8'(10 + i);
            src_event[i].material = 8'(8'hA0 + i);
        end
        tick(); tick();
        armed = 1'b1;
        chk("rst.busy",      64'(busy0),          64'd0);
        chk("rst.issued",    64'(iss0),           64'd0);
        chk("rst.wr_valid",  64'(bus0.wr_valid),  64'd0);
        chk("rst.src_ready", 64'(bus0.src_ready), 64'd0);
        reset = 1'b0; tick();

        // all four lanes streaming: strict rotation
        start_frame();
        gq.delete();
        src_valid = 4'hF;
        repeat (8) tick();
        src_valid = '0; tick();
        chk("A.ngrants", 64'(gq.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < gq.size()) chk("A.grant", 64'(gq[i]), 64'(i % 4));
        chk("A.issued256", 64'(iss0), 64'd8);
        chk("A.issued4",   64'(iss1), 64'd4);
        chk("A.drop4",     64'(drp1), 64'd4);
        end_frame();

        // overflow of the small buffer: six transfers from lane 2
        start_frame();
        n_wv1 = 0; n_dp1 = 0; n_rdy2 = 0;
        src_valid = 4'b0100;
        repeat (6) tick();
        src_valid = '0; tick();
        chk("B.wr_valid4",  64'(n_wv1),  64'd4);
        chk("B.drop_pulse", 64'(n_dp1),  64'd2);
        chk("B.ready_lane2",64'(n_rdy2), 64'd6);
        chk("B.drop4",      64'(drp1),   64'd2);
        chk("B.issued4",    64'(iss1),   64'd4);
        chk("B.issued256",  64'(iss0),   64'd6);
        end_frame();

        // frame_req+frame_end in idle, frame_req while active, transfer on frame_end
        frame_req = 1'b1; frame_end = 1'b1; tick();
        chk("C.frame_start", 64'(bus0.wr_frame_start), 64'd1);
        chk("C.busy",        64'(busy0),               64'd1);
        frame_req = 1'b0; frame_end = 1'b0; tick();
        chk("C.frame_start_off", 64'(bus0.wr_frame_start), 64'd0);
        frame_req = 1'b1; tick();
        frame_req = 1'b0;
        chk("C.req_active_fs",   64'(bus0.wr_frame_start), 64'd0);
        chk("C.req_active_busy", 64'(busy0),               64'd1);
        src_valid = 4'b0010; frame_end = 1'b1; tick();
        src_valid = '0; frame_end = 1'b0;
        chk("C.end_wr_valid", 64'(bus0.wr_valid), 64'd1);
        chk("C.end_wr_event", 64'(bus0.wr_event), 64'(src_event[1]));
        chk("C.end_issued",   64'(iss0),          64'd1);
        chk("C.done_t1",      64'(done0),         64'd0);
        tick();
        chk("C.done_t2",      64'(done0),         64'd1);
        chk("C.busy_t2",      64'(busy0),         64'd0);
        tick();
        chk("C.done_t3",      64'(done0),         64'd0);

        // lane 3 last granted, then lanes 0 and 3 compete
        start_frame();
        src_valid = 4'b1000; tick();
        gq.delete();
        src_valid = 4'b1001; tick(); tick();
        src_valid = '0;
        chk("D.ngrants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("D.grant0", 64'(gq[0]), 64'd0);
            chk("D.grant1", 64'(gq[1]), 64'd3);
        end

        // reset mid-frame with an event sitting in the output register
        src_valid = 4'b0001; tick();
        src_valid = '0;
        chk("R.inflight", 64'(bus0.wr_valid), 64'd1);
        reset = 1'b1; tick();
        chk("R.busy",      64'(busy0),               64'd0);
        chk("R.wr_valid",  64'(bus0.wr_valid),       64'd0);
        chk("R.fs",        64'(bus0.wr_frame_start), 64'd0);
        chk("R.done",      64'(done0),               64'd0);
        chk("R.issued",    64'(iss0),                64'd0);
        chk("R.drop",      64'(drp0),                64'd0);
        chk("R.wr_event",  64'(bus0.wr_event),       64'd0);
        chk("R.src_ready", 64'(bus0.src_ready),      64'd0);
        reset = 1'b0; tick();
        chk("R.post_wr_valid", 64'(bus0.wr_valid), 64'd0);
        chk("R.post_busy",     64'(busy0),         64'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
